// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The slave side is the adder; the master side supplies operands and consumes results.
interface serial_adder_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial W-bit adder: one 2-bit ripple slice, LSB digit first.
// The sum digits shift in from the top so the finished sum is aligned after W/2 steps.
module serial_adder #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave io
);

  localparam int ND = W / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  generate
    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
      $error("serial_adder: W must be even and >= 2");
    end
  endgenerate

  // Returns {cout, s1, s0} of a 2-bit ripple add.
  function automatic logic [2:0] slice_add2(input logic [1:0] x, input logic [1:0] y,
                                            input logic ci);
    slice_add2 = {1'b0, x} + {1'b0, y} + {2'b00, ci};
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    s_sh_r;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      slice_s;
  logic [W+1:0]    s_cat_s;

  assign slice_s = slice_add2(a_sh_r[1:0], b_sh_r[1:0], carry_r);
  assign s_cat_s = {slice_s[1:0], s_sh_r};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (io.in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand shifters, sum accumulator, carry and digit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      s_sh_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (io.in_valid) begin
            a_sh_r  <= io.a;
            b_sh_r  <= io.b;
            carry_r <= io.cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> 2;
          b_sh_r  <= b_sh_r >> 2;
          s_sh_r  <= s_cat_s[W+1:2];
          carry_r <= slice_s[2];
          cnt_r   <= cnt_r + CW'(1);
        end
        default: begin
          a_sh_r <= a_sh_r;
        end
      endcase
    end
  end

  // Handshake outputs are plain state decodes; results come straight from registers.
  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    case (state_r)
      IDLE:    io.in_ready  = 1'b1;
      DONE:    io.out_valid = 1'b1;
      default: io.in_ready  = 1'b0;
    endcase
    io.sum  = s_sh_r;
    io.cout = carry_r;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder at W=8, plus a W=2 instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.W(8)) bus8 ();
  serial_adder_if #(.W(2)) bus2 ();

  serial_adder #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(bus8.slave));
  serial_adder #(.W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io(bus2.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One W=8 operation with out_ready already high; checks latency, result and return to IDLE.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec, input string tag);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = ci;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd4);
    check_eq({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    @(negedge clk);
    check_eq({tag, "_idle_ready"}, 32'(bus8.in_ready), 32'd1);
    check_eq({tag, "_idle_valid"}, 32'(bus8.out_valid), 32'd0);
  endtask

  logic [7:0]  va [100];
  logic [7:0]  vb [100];
  logic        vc [100];
  logic [31:0] q [$];

  initial begin
    int lat;
    int seen;
    int idx;
    int got;
    int cyc;
    logic [31:0] exp_w;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check_eq("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("rst_sum", 32'(bus8.sum), 32'd0);
    check_eq("rst_cout", 32'(bus8.cout), 32'd0);
    check_eq("rst2_in_ready", 32'(bus2.in_ready), 32'd1);

    // Basic add and carry-chain cases
    bus8.out_ready = 1'b1;
    run_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "chain1");
    run_op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "chain2");
    run_op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "chain3");

    // Back-pressure: hold DONE for 10 cycles while in_valid is pulsed with 0xAA
    bus8.out_ready = 1'b0;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus8.in_valid = i[0];
      bus8.a = 8'hAA; bus8.b = 8'hAA; bus8.cin = 1'b0;
      check_eq("bp_in_ready", 32'(bus8.in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      check_eq("bp_sum", 32'(bus8.sum), 32'h47);
      check_eq("bp_cout", 32'(bus8.cout), 32'd0);
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("bp_release_ready", 32'(bus8.in_ready), 32'd1);

    // Reset during the second RUN cycle
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mrst_in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("mrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("mrst_sum", 32'(bus8.sum), 32'd0);
    check_eq("mrst_cout", 32'(bus8.cout), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check_eq("mrst_no_stale", 32'(seen), 32'd0);

    // Back-to-back random vectors with random back-pressure
    for (int i = 0; i < 100; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vc[i] = 1'($urandom);
    end
    idx = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus8.in_valid = (idx < 100);
      if (idx < 100) begin
        bus8.a = va[idx]; bus8.b = vb[idx]; bus8.cin = vc[idx];
      end
      bus8.out_ready = 1'($urandom_range(0, 1));
      if (bus8.in_valid && bus8.in_ready) begin
        q.push_back(32'({1'b0, va[idx]} + {1'b0, vb[idx]} + 9'(vc[idx])));
        idx++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (q.size() > 0) exp_w = q.pop_front();
        else exp_w = 32'hFFFF_FFFF;
        check_eq("rnd_result", {23'd0, bus8.cout, bus8.sum}, exp_w);
        got++;
      end
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    check_eq("rnd_count", 32'(got), 32'd100);
    check_eq("rnd_leftover", 32'(q.size()), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check_eq("rnd_no_dup", 32'(seen), 32'd0);

    // W=2 instance: single RUN cycle
    @(negedge clk);
    check_eq("w2_in_ready", 32'(bus2.in_ready), 32'd1);
    bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1; bus2.a = 2'd3; bus2.b = 2'd3; bus2.cin = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("w2_latency", 32'(lat), 32'd1);
    check_eq("w2_sum", 32'(bus2.sum), 32'd3);
    check_eq("w2_cout", 32'(bus2.cout), 32'd1);
    @(negedge clk);
    check_eq("w2_idle", 32'(bus2.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
